// File: rtl/display_pkg.sv
// Shared constants, types and small helpers for the four-digit hex display scanner.
package display_pkg;

  localparam int DIGITS   = 4;
  localparam int NIBBLE_W = 4;
  localparam int DATA_W   = DIGITS * NIBBLE_W;

  localparam logic [DIGITS-1:0] ANODE_OFF = 4'b1111;
  localparam logic [DIGITS-1:0] ANODE_RST = 4'b1110;

  typedef logic [1:0] digit_idx_t;

  // Where the display register takes its next value from on a frame edge.
  typedef enum logic [1:0] {
    COMMIT_NONE    = 2'd0,
    COMMIT_PENDING = 2'd1,
    COMMIT_BYPASS  = 2'd2
  } commit_src_t;

  function automatic logic [NIBBLE_W-1:0] get_nibble(input logic [DATA_W-1:0] value,
                                                     input digit_idx_t         idx);
    return value[int'(idx)*NIBBLE_W +: NIBBLE_W];
  endfunction

  function automatic logic [DIGITS-1:0] anode_for(input digit_idx_t idx);
    logic [DIGITS-1:0] anode;
    anode      = ANODE_OFF;
    anode[idx] = 1'b0;
    return anode;
  endfunction

  // A digit above position 0 is a leading zero when it and every digit above it are zero.
  function automatic logic leading_zero(input logic [DATA_W-1:0] value,
                                        input digit_idx_t         idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(idx)) && (value[i*NIBBLE_W +: NIBBLE_W] != '0)) begin
        all_zero = 1'b0;
      end
    end
    return (idx != 2'd0) && all_zero;
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Load/data/blank inputs and scanned digit outputs of the hex display scanner.
interface hex_display_scanner_if;

  logic                                load;
  logic [display_pkg::DATA_W-1:0]      data_in;
  logic                                lz_blank;
  logic [display_pkg::NIBBLE_W-1:0]    nibble_out;
  logic [display_pkg::DIGITS-1:0]      digit_en;
  logic                                ack;

  modport master (
    output load,
    output data_in,
    output lz_blank,
    input  nibble_out,
    input  digit_en,
    input  ack
  );

  modport slave (
    input  load,
    input  data_in,
    input  lz_blank,
    output nibble_out,
    output digit_en,
    output ack
  );

endinterface

// File: rtl/refresh_divider.sv
// Free-running divider producing a one-cycle tick every REFRESH_DIV clocks.
module refresh_divider #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed four-digit hex display scanner with frame-aligned commit and leading-zero blanking.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  hex_display_scanner_if.slave  bus
);

  logic tick;

  refresh_divider #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh_divider (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  digit_idx_t          idx_q,        idx_d;
  logic [DATA_W-1:0]   display_q,    display_d;
  logic [DATA_W-1:0]   pend_q,       pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic [NIBBLE_W-1:0] nibble_q,     nibble_d;
  logic [DIGITS-1:0]   digit_en_q,   digit_en_d;
  logic                ack_q,        ack_d;

  logic                frame_edge;
  commit_src_t         commit_src;

  // A load on the frame edge itself wins over anything still pending.
  always_comb begin
    frame_edge = tick && (idx_q == 2'd3);
    commit_src = COMMIT_NONE;
    if (frame_edge) begin
      if (bus.load) begin
        commit_src = COMMIT_BYPASS;
      end else if (pend_valid_q) begin
        commit_src = COMMIT_PENDING;
      end
    end
  end

  always_comb begin
    display_d    = display_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ack_d        = 1'b0;
    case (commit_src)
      COMMIT_BYPASS: begin
        display_d    = bus.data_in;
        pend_valid_d = 1'b0;
        ack_d        = 1'b1;
      end
      COMMIT_PENDING: begin
        display_d    = pend_q;
        pend_valid_d = 1'b0;
        ack_d        = 1'b1;
      end
      default: begin
        if (bus.load) begin
          pend_d       = bus.data_in;
          pend_valid_d = 1'b1;
        end
      end
    endcase
  end

  // Outputs are built from display_d so the frame edge already shows the new value.
  always_comb begin
    idx_d      = idx_q;
    nibble_d   = nibble_q;
    digit_en_d = digit_en_q;
    if (tick) begin
      idx_d    = idx_q + 2'd1;
      nibble_d = get_nibble(display_d, idx_d);
      if (bus.lz_blank && leading_zero(display_d, idx_d)) begin
        digit_en_d = ANODE_OFF;
      end else begin
        digit_en_d = anode_for(idx_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= 2'd0;
      display_q    <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      nibble_q     <= '0;
      digit_en_q   <= ANODE_RST;
      ack_q        <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      display_q    <= display_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      nibble_q     <= nibble_d;
      digit_en_q   <= digit_en_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.nibble_out = nibble_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.ack        = ack_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed self-checking bench for hex_display_scanner with a 4-clock slot.
module tb_hex_display_scanner;

  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  hex_display_scanner_if bus ();

  hex_display_scanner #(
    .REFRESH_DIV (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset release; slot boundaries fall on multiples of 4, frames on 16.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) begin
      $display("[TB] FAIL run_to_timeout got=%0d exp=%0d", cyc, n);
      errors++;
    end
  endtask

  task automatic pulse_load(input logic [15:0] value);
    bus.load    = 1'b1;
    bus.data_in = value;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    bus.load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_en [4];
    exp_en = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.nibble_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_nibble got=%h exp=0", bus.nibble_out); end
    checks++; if (bus.digit_en !== 4'b1110) begin errors++; $display("[TB] FAIL reset_digit_en got=%b exp=1110", bus.digit_en); end
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got=%b exp=0", bus.ack); end
    @(negedge clk);
    rst = 1'b0;
    run_to(3);
    checks++; if (bus.digit_en !== 4'b1110) begin errors++; $display("[TB] FAIL first_tick_early got=%b exp=1110", bus.digit_en); end
    for (int s = 0; s < 4; s++) begin
      run_to(4 + 4*s);
      checks++; if (bus.digit_en !== exp_en[s]) begin errors++; $display("[TB] FAIL idle_scan cyc=%0d got=%b exp=%b", cyc, bus.digit_en, exp_en[s]); end
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack cyc=%0d got=%b exp=0", cyc, bus.ack); end
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_nib [4];
    logic [3:0] exp_en  [4];
    exp_nib = '{4'h4, 4'h3, 4'h2, 4'h1};
    exp_en  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset();
    run_to(1);
    pulse_load(16'h1234);
    run_to(15);
    checks++; if (bus.nibble_out !== 4'h0 || bus.digit_en !== 4'b0111) begin errors++; $display("[TB] FAIL scan_precommit got=%h/%b exp=0/0111", bus.nibble_out, bus.digit_en); end
    run_to(16);
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("[TB] FAIL scan_ack got=%b exp=1", bus.ack); end
    run_to(17);
    checks++; if (bus.ack !== 1'b0 || bus.nibble_out !== 4'h4) begin errors++; $display("[TB] FAIL scan_hold got=%b/%h exp=0/4", bus.ack, bus.nibble_out); end
    for (int s = 0; s < 5; s++) begin
      run_to(16 + 4*s);
      checks++; if (bus.nibble_out !== exp_nib[s%4]) begin errors++; $display("[TB] FAIL scan_nibble cyc=%0d got=%h exp=%h", cyc, bus.nibble_out, exp_nib[s%4]); end
      checks++; if (bus.digit_en !== exp_en[s%4]) begin errors++; $display("[TB] FAIL scan_digit_en cyc=%0d got=%b exp=%b", cyc, bus.digit_en, exp_en[s%4]); end
    end
  endtask

  task automatic test_commit_timing();
    int acks;
    acks = 0;
    do_reset();
    run_to(5);
    pulse_load(16'hBEEF);
    for (int c = 6; c <= 31; c++) begin
      run_to(c);
      if (bus.ack === 1'b1) acks++;
      if (c == 16) begin
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("[TB] FAIL commit_ack got=%b exp=1", bus.ack); end
        checks++; if (bus.nibble_out !== 4'hF || bus.digit_en !== 4'b1110) begin errors++; $display("[TB] FAIL commit_first got=%h/%b exp=f/1110", bus.nibble_out, bus.digit_en); end
      end
      if (c == 28) begin
        checks++; if (bus.nibble_out !== 4'hB || bus.digit_en !== 4'b0111) begin errors++; $display("[TB] FAIL commit_last got=%h/%b exp=b/0111", bus.nibble_out, bus.digit_en); end
      end
    end
    checks++; if (acks != 1) begin errors++; $display("[TB] FAIL commit_ack_count got=%0d exp=1", acks); end
  endtask

  task automatic test_overwrite();
    int   acks;
    logic seen_old;
    acks     = 0;
    seen_old = 1'b0;
    do_reset();
    run_to(2);
    pulse_load(16'h1111);
    run_to(8);
    pulse_load(16'h2222);
    for (int c = 9; c <= 35; c++) begin
      run_to(c);
      if (bus.ack === 1'b1) acks++;
      if (bus.nibble_out === 4'h1) seen_old = 1'b1;
      if (c == 20) begin
        checks++; if (bus.nibble_out !== 4'h2 || bus.digit_en !== 4'b1101) begin errors++; $display("[TB] FAIL overwrite_value got=%h/%b exp=2/1101", bus.nibble_out, bus.digit_en); end
      end
    end
    checks++; if (acks != 1) begin errors++; $display("[TB] FAIL overwrite_ack_count got=%0d exp=1", acks); end
    checks++; if (seen_old !== 1'b0) begin errors++; $display("[TB] FAIL overwrite_stale got=%b exp=0", seen_old); end
  endtask

  task automatic test_bypass();
    int acks;
    acks = 0;
    do_reset();
    run_to(3);
    pulse_load(16'h1111);
    run_to(15);
    pulse_load(16'hA5A5);
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("[TB] FAIL bypass_ack got=%b exp=1", bus.ack); end
    checks++; if (bus.nibble_out !== 4'h5 || bus.digit_en !== 4'b1110) begin errors++; $display("[TB] FAIL bypass_first got=%h/%b exp=5/1110", bus.nibble_out, bus.digit_en); end
    for (int c = 17; c <= 35; c++) begin
      run_to(c);
      if (bus.ack === 1'b1) acks++;
      if (c == 20) begin
        checks++; if (bus.nibble_out !== 4'hA) begin errors++; $display("[TB] FAIL bypass_digit1 got=%h exp=a", bus.nibble_out); end
      end
      if (c == 32) begin
        checks++; if (bus.nibble_out !== 4'h5) begin errors++; $display("[TB] FAIL bypass_discard got=%h exp=5", bus.nibble_out); end
      end
    end
    checks++; if (acks != 0) begin errors++; $display("[TB] FAIL bypass_extra_ack got=%0d exp=0", acks); end
  endtask

  task automatic test_blanking();
    logic [3:0] exp_nib [4];
    logic [3:0] exp_en  [4];
    exp_nib = '{4'h2, 4'h4, 4'h0, 4'h0};
    exp_en  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    do_reset();
    bus.lz_blank = 1'b1;
    run_to(1);
    pulse_load(16'h0042);
    run_to(4);
    checks++; if (bus.digit_en !== 4'b1111) begin errors++; $display("[TB] FAIL blank_zero_slot1 got=%b exp=1111", bus.digit_en); end
    for (int s = 0; s < 4; s++) begin
      run_to(16 + 4*s);
      checks++; if (bus.nibble_out !== exp_nib[s] || bus.digit_en !== exp_en[s]) begin errors++; $display("[TB] FAIL blank_0042 cyc=%0d got=%h/%b exp=%h/%b", cyc, bus.nibble_out, bus.digit_en, exp_nib[s], exp_en[s]); end
    end
    run_to(29);
    pulse_load(16'h0000);
    run_to(32);
    checks++; if (bus.nibble_out !== 4'h0 || bus.digit_en !== 4'b1110 || bus.ack !== 1'b1) begin errors++; $display("[TB] FAIL blank_all_zero_d0 got=%h/%b/%b exp=0/1110/1", bus.nibble_out, bus.digit_en, bus.ack); end
    run_to(36);
    checks++; if (bus.digit_en !== 4'b1111) begin errors++; $display("[TB] FAIL blank_all_zero_d1 got=%b exp=1111", bus.digit_en); end
    bus.lz_blank = 1'b0;
    run_to(40);
    checks++; if (bus.nibble_out !== 4'h0 || bus.digit_en !== 4'b1011) begin errors++; $display("[TB] FAIL blank_mid_frame got=%h/%b exp=0/1011", bus.nibble_out, bus.digit_en); end
    run_to(44);
    checks++; if (bus.digit_en !== 4'b0111) begin errors++; $display("[TB] FAIL unblank_d3 got=%b exp=0111", bus.digit_en); end
  endtask

  task automatic test_reset_mid();
    int   acks;
    logic seen_nine;
    acks      = 0;
    seen_nine = 1'b0;
    do_reset();
    run_to(5);
    pulse_load(16'h9999);
    run_to(10);
    rst = 1'b1;
    #1;
    checks++; if (bus.nibble_out !== 4'h0 || bus.digit_en !== 4'b1110 || bus.ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_outputs got=%h/%b/%b exp=0/1110/0", bus.nibble_out, bus.digit_en, bus.ack); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      run_to(c);
      if (bus.ack === 1'b1) acks++;
      if (bus.nibble_out === 4'h9) seen_nine = 1'b1;
      if (c == 20) begin
        checks++; if (bus.nibble_out !== 4'h0 || bus.digit_en !== 4'b1101) begin errors++; $display("[TB] FAIL mid_reset_display got=%h/%b exp=0/1101", bus.nibble_out, bus.digit_en); end
      end
    end
    checks++; if (acks != 0) begin errors++; $display("[TB] FAIL mid_reset_ack got=%0d exp=0", acks); end
    checks++; if (seen_nine !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_stale got=%b exp=0", seen_nine); end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.data_in  = 16'h0000;
    bus.lz_blank = 1'b0;
    test_reset();
    test_scan();
    test_commit_timing();
    test_overwrite();
    test_bypass();
    test_blanking();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
